// File: rtl/sayuru_wb_pkg.sv
// Shared types and helpers for the sayuru posted-write buffer.
// Entry layout, FSM state encodings and the word-address compare.
// Entry widths come from the package constants; the top-level parameters default to them.
package sayuru_wb_pkg;

  localparam int WB_ADDR_W = 16;
  localparam int WB_DATA_W = 32;
  localparam int WB_BE_W   = WB_DATA_W / 8;

  // One buffered write: target address, byte enables and write data.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_BE_W-1:0]   be;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Cache-facing FSM.
  typedef logic [2:0] up_state_t;
  localparam up_state_t U_IDLE    = 3'd0;
  localparam up_state_t U_GNT     = 3'd1;
  localparam up_state_t U_RESP    = 3'd2;
  localparam up_state_t U_RD_WAIT = 3'd3;
  localparam up_state_t U_RD_MEM  = 3'd4;

  // Memory-facing FSM.
  typedef logic [1:0] dn_state_t;
  localparam dn_state_t D_IDLE        = 2'd0;
  localparam dn_state_t D_REQ         = 2'd1;
  localparam dn_state_t D_WAIT_RVALID = 2'd2;

  // Two addresses hit the same word when everything above the byte offset agrees.
  function automatic logic word_match(input logic [WB_ADDR_W-1:0] a,
                                      input logic [WB_ADDR_W-1:0] b);
    return a[WB_ADDR_W-1:2] == b[WB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sayuru_wb_fifo.sv
// Entry storage for the posted-write buffer with a youngest-match address lookup.
// Latency: push visible one cycle later; head and lookup are combinational from stored state.
// Backpressure: caller must not push when full or pop when empty; full/empty are registered-state flags.
module sayuru_wb_fifo
  import sayuru_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_vld,
  input  wb_entry_t            push_dat,
  input  logic                 pop_vld,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] occupancy,
  output wb_entry_t            head_dat,
  input  logic [WB_ADDR_W-1:0] lookup_addr,
  output logic                 lookup_hit,
  output logic                 lookup_full_word,
  output logic [WB_DATA_W-1:0] lookup_dat,
  output logic                 lookup_partial
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [AW-1:0]     lk_idx;

  // Extra pointer MSB distinguishes full from empty when the index bits coincide.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign head_dat  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_vld && !full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_vld  && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage; stale contents are unreachable once the pointers are reset.
  always_ff @(posedge clk_i) begin
    if (push_vld && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  // Walk oldest to youngest so the last valid match left standing is the youngest one.
  always_comb begin
    lookup_hit       = 1'b0;
    lookup_full_word = 1'b0;
    lookup_dat       = '0;
    lookup_partial   = 1'b0;
    lk_idx           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr_q[AW-1:0] + AW'(i);
      if ((PW'(i) < occupancy) && word_match(mem_q[lk_idx].addr, lookup_addr)) begin
        lookup_hit       = 1'b1;
        lookup_full_word = &mem_q[lk_idx].be;
        lookup_dat       = mem_q[lk_idx].data;
        if (!(&mem_q[lk_idx].be)) lookup_partial = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sayuru_write_buffer.sv
// Posted-write buffer between the data cache memory port and data memory.
// Latency: buffered write or forwarded read gnt at +1, rvalid at +2; other reads follow memory plus one cycle each way.
// Backpressure: cache writes stall (no gnt) while the buffer is full; reads wait for the drain engine and any partial-word conflict.
module sayuru_write_buffer
  import sayuru_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_data_req_i,
  input  logic [ADDR_WIDTH-1:0]   in_data_addr_i,
  input  logic                    in_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] in_data_be_i,
  input  logic [DATA_WIDTH-1:0]   in_data_wdata_i,
  output logic                    in_data_gnt_o,
  output logic                    in_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   in_data_rdata_o,
  output logic                    out_data_req_o,
  output logic [ADDR_WIDTH-1:0]   out_data_addr_o,
  output logic                    out_data_we_o,
  output logic [DATA_WIDTH/8-1:0] out_data_be_o,
  output logic [DATA_WIDTH-1:0]   out_data_wdata_o,
  input  logic                    out_data_gnt_i,
  input  logic                    out_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   out_data_rdata_i,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output int                      forward_count,
  output int                      drain_count,
  output int                      full_stall_count
);

  up_state_t                u_state_q;
  dn_state_t                d_state_q;
  logic [ADDR_WIDTH-1:0]    rd_addr_q;
  logic [DATA_WIDTH/8-1:0]  rd_be_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     rd_gnt_q;
  logic                     d_is_rd_q;

  logic                     in_wr;
  logic                     in_rd;
  logic                     push_vld;
  wb_entry_t                push_dat;
  logic                     pop_vld;
  logic                     fifo_full;
  logic                     fifo_empty;
  wb_entry_t                head_dat;
  logic [ADDR_WIDTH-1:0]    lookup_addr;
  logic                     lk_hit;
  logic                     lk_full_word;
  logic [DATA_WIDTH-1:0]    lk_dat;
  logic                     lk_partial;
  logic                     fwd_hit;
  logic                     rd_start;

  assign in_wr = in_data_req_i &  in_data_we_i;
  assign in_rd = in_data_req_i & ~in_data_we_i;

  // Full is the registered flag, so a slot freed this cycle is only usable next cycle.
  assign push_vld = (u_state_q == U_IDLE) && in_wr && !fifo_full;

  // Assemble the entry pushed for an accepted cache write.
  always_comb begin
    push_dat      = '0;
    push_dat.addr = in_data_addr_i;
    push_dat.be   = in_data_be_i;
    push_dat.data = in_data_wdata_i;
  end

  // While a read is parked the live cache address is not trusted; use the latched copy.
  assign lookup_addr = (u_state_q == U_IDLE) ? in_data_addr_i : rd_addr_q;
  assign fwd_hit     = (u_state_q == U_IDLE) && in_rd && lk_hit && lk_full_word;

  // A parked read goes to memory once the drain engine is free; a partial-word
  // conflict additionally needs every buffered write to have landed first.
  assign rd_start = (u_state_q == U_RD_WAIT) && (d_state_q == D_IDLE) &&
                    (!lk_partial || fifo_empty);

  assign pop_vld = (d_state_q == D_WAIT_RVALID) && out_data_rvalid_i && !d_is_rd_q;

  assign in_data_gnt_o    = (u_state_q == U_GNT) || rd_gnt_q;
  assign in_data_rvalid_o = (u_state_q == U_RESP);
  assign in_data_rdata_o  = rdata_q;

  sayuru_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .push_vld         (push_vld),
    .push_dat         (push_dat),
    .pop_vld          (pop_vld),
    .full             (fifo_full),
    .empty            (fifo_empty),
    .occupancy        (occupancy_o),
    .head_dat         (head_dat),
    .lookup_addr      (lookup_addr),
    .lookup_hit       (lk_hit),
    .lookup_full_word (lk_full_word),
    .lookup_dat       (lk_dat),
    .lookup_partial   (lk_partial)
  );

  // Cache-facing FSM: accept writes into the buffer, forward or park reads, sequence gnt/rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      u_state_q        <= U_IDLE;
      rd_addr_q        <= '0;
      rd_be_q          <= '0;
      rdata_q          <= '0;
      rd_gnt_q         <= 1'b0;
      forward_count    <= 0;
      full_stall_count <= 0;
    end else begin
      rd_gnt_q <= 1'b0;
      case (u_state_q)
        U_IDLE: begin
          if (in_wr) begin
            if (!fifo_full) begin
              rdata_q   <= '0;
              u_state_q <= U_GNT;
            end else begin
              full_stall_count <= full_stall_count + 1;
            end
          end else if (in_rd) begin
            rd_addr_q <= in_data_addr_i;
            rd_be_q   <= in_data_be_i;
            if (fwd_hit) begin
              // Latched here so a same-cycle pop of the matched entry cannot disturb it.
              rdata_q       <= lk_dat;
              forward_count <= forward_count + 1;
              u_state_q     <= U_GNT;
            end else begin
              u_state_q <= U_RD_WAIT;
            end
          end
        end
        U_GNT:     u_state_q <= U_RESP;
        U_RESP:    u_state_q <= U_IDLE;
        U_RD_WAIT: if (rd_start) u_state_q <= U_RD_MEM;
        U_RD_MEM: begin
          // Only our read can be in flight downstream while we sit here.
          if ((d_state_q == D_REQ) && out_data_gnt_i) rd_gnt_q <= 1'b1;
          if ((d_state_q == D_WAIT_RVALID) && out_data_rvalid_i) begin
            rdata_q   <= out_data_rdata_i;
            u_state_q <= U_RESP;
          end
        end
        default:   u_state_q <= U_IDLE;
      endcase
    end
  end

  // Memory-facing FSM: issue the parked read first, otherwise drain the FIFO head in order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_state_q        <= D_IDLE;
      d_is_rd_q        <= 1'b0;
      out_data_req_o   <= 1'b0;
      out_data_addr_o  <= '0;
      out_data_we_o    <= 1'b0;
      out_data_be_o    <= '0;
      out_data_wdata_o <= '0;
      drain_count      <= 0;
    end else begin
      case (d_state_q)
        D_IDLE: begin
          if (rd_start) begin
            out_data_req_o   <= 1'b1;
            out_data_addr_o  <= rd_addr_q;
            out_data_we_o    <= 1'b0;
            out_data_be_o    <= rd_be_q;
            out_data_wdata_o <= '0;
            d_is_rd_q        <= 1'b1;
            d_state_q        <= D_REQ;
          end else if (!fifo_empty) begin
            out_data_req_o   <= 1'b1;
            out_data_addr_o  <= head_dat.addr;
            out_data_we_o    <= 1'b1;
            out_data_be_o    <= head_dat.be;
            out_data_wdata_o <= head_dat.data;
            d_is_rd_q        <= 1'b0;
            d_state_q        <= D_REQ;
          end
        end
        D_REQ: begin
          if (out_data_gnt_i) begin
            out_data_req_o   <= 1'b0;
            out_data_addr_o  <= '0;
            out_data_we_o    <= 1'b0;
            out_data_be_o    <= '0;
            out_data_wdata_o <= '0;
            d_state_q        <= D_WAIT_RVALID;
          end
        end
        D_WAIT_RVALID: begin
          // The head entry remains forwardable until this pop.
          if (out_data_rvalid_i) begin
            if (!d_is_rd_q) drain_count <= drain_count + 1;
            d_state_q <= D_IDLE;
          end
        end
        default: d_state_q <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sayuru_write_buffer.sv
// Directed bench for sayuru_write_buffer with a small behavioural data memory.
// Latency of each cache transaction is measured in clk_i cycles from the request edge.
// Memory grant can be stalled and its rvalid delayed to create backpressure scenarios.
module tb_sayuru_write_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_data_req_i = 1'b0;
  logic [15:0] in_data_addr_i = '0;
  logic        in_data_we_i = 1'b0;
  logic [3:0]  in_data_be_i = '0;
  logic [31:0] in_data_wdata_i = '0;
  logic        in_data_gnt_o;
  logic        in_data_rvalid_o;
  logic [31:0] in_data_rdata_o;
  logic        out_data_req_o;
  logic [15:0] out_data_addr_o;
  logic        out_data_we_o;
  logic [3:0]  out_data_be_o;
  logic [31:0] out_data_wdata_o;
  logic        out_data_gnt_i = 1'b0;
  logic        out_data_rvalid_i = 1'b0;
  logic [31:0] out_data_rdata_i = '0;
  logic [2:0]  occupancy_o;
  int          forward_count;
  int          drain_count;
  int          full_stall_count;

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic        mem_stall = 1'b1;
  int          rv_delay = 0;
  logic [31:0] mem [0:255];
  logic        mem_init_done = 1'b0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_rdata = '0;
  logic [15:0] log_addr [$];
  logic        log_we [$];
  logic [31:0] log_wdata [$];

  int          g, r;
  logic [31:0] d;

  always #5 clk_i = ~clk_i;

  sayuru_write_buffer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_data_req_i    (in_data_req_i),
    .in_data_addr_i   (in_data_addr_i),
    .in_data_we_i     (in_data_we_i),
    .in_data_be_i     (in_data_be_i),
    .in_data_wdata_i  (in_data_wdata_i),
    .in_data_gnt_o    (in_data_gnt_o),
    .in_data_rvalid_o (in_data_rvalid_o),
    .in_data_rdata_o  (in_data_rdata_o),
    .out_data_req_o   (out_data_req_o),
    .out_data_addr_o  (out_data_addr_o),
    .out_data_we_o    (out_data_we_o),
    .out_data_be_o    (out_data_be_o),
    .out_data_wdata_o (out_data_wdata_o),
    .out_data_gnt_i   (out_data_gnt_i),
    .out_data_rvalid_i(out_data_rvalid_i),
    .out_data_rdata_i (out_data_rdata_i),
    .occupancy_o      (occupancy_o),
    .forward_count    (forward_count),
    .drain_count      (drain_count),
    .full_stall_count (full_stall_count)
  );

  // Memory: word i initially holds A500_0000|i; grant decided on the falling edge, rvalid rv_delay cycles later.
  always @(negedge clk_i) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      mem_init_done = 1'b1;
    end
    out_data_gnt_i    = 1'b0;
    out_data_rvalid_i = 1'b0;
    out_data_rdata_i  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        out_data_rvalid_i = 1'b1;
        out_data_rdata_i  = pend_rdata;
        pend = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end else if (out_data_req_o && !mem_stall) begin
      out_data_gnt_i = 1'b1;
      log_addr.push_back(out_data_addr_o);
      log_we.push_back(out_data_we_o);
      log_wdata.push_back(out_data_wdata_o);
      if (out_data_we_o) begin
        for (int b = 0; b < 4; b++)
          if (out_data_be_o[b]) mem[out_data_addr_o[9:2]][8*b +: 8] = out_data_wdata_o[8*b +: 8];
        pend_rdata = '0;
      end else begin
        pend_rdata = mem[out_data_addr_o[9:2]];
      end
      pend = 1'b1;
      pend_cnt = rv_delay;
    end
  end

  // One cache transaction; cycles counted from the falling edge where the request is driven.
  task automatic cache_req(input logic [15:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, output int gcyc, output int rcyc,
                           output logic [31:0] rd);
    int c;
    logic got;
    c = 0; got = 1'b0; gcyc = -1; rcyc = -1; rd = '0;
    @(negedge clk_i);
    in_data_req_i = 1'b1; in_data_addr_i = a; in_data_we_i = we;
    in_data_be_i = be; in_data_wdata_i = wd;
    while (c < 300 && rcyc < 0) begin
      @(negedge clk_i);
      c++;
      if (got) in_data_req_i = 1'b0;
      if (in_data_gnt_o && !got) begin got = 1'b1; gcyc = c; end
      if (in_data_rvalid_o) begin rcyc = c; rd = in_data_rdata_o; end
    end
    in_data_req_i = 1'b0; in_data_we_i = 1'b0; in_data_be_i = '0;
    in_data_addr_i = '0; in_data_wdata_i = '0;
    if (rcyc < 0) begin
      checks++; errors++;
      $display("FAIL cache_req_timeout addr=%h: no rvalid within 300 cycles", a);
    end
  endtask

  // Release memory and wait for the buffer and memory to go quiet.
  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    mem_stall = 1'b0;
    while (n < 200 && !(occupancy_o == 3'd0 && !out_data_req_o && !pend)) begin
      @(negedge clk_i); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain_timeout: occupancy=%0d req=%0b after 200 cycles, required empty", tag, occupancy_o, out_data_req_o);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_data_gnt_o, in_data_rvalid_o, out_data_req_o, out_data_we_o} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 0000", {in_data_gnt_o, in_data_rvalid_o, out_data_req_o, out_data_we_o});
    end
    checks++;
    if ({in_data_rdata_o, out_data_addr_o, out_data_be_o, out_data_wdata_o} !== 84'd0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", {in_data_rdata_o, out_data_addr_o, out_data_be_o, out_data_wdata_o});
    end
    checks++;
    if (occupancy_o !== 3'd0 || forward_count !== 0 || drain_count !== 0 || full_stall_count !== 0) begin
      errors++; $display("FAIL reset_counters: occ=%0d fwd=%0d drn=%0d stall=%0d, required all 0", occupancy_o, forward_count, drain_count, full_stall_count);
    end
    @(negedge clk_i); #2 rst_ni = 1'b1;
  endtask

  task automatic test_single_write();
    mem_stall = 1'b1;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    cache_req(16'h0010, 1'b1, 4'hF, 32'hDEAD_BEEF, g, r, d);
    checks++; if (g !== 1) begin errors++; $display("FAIL wr_gnt_latency: got %0d, required 1", g); end
    checks++; if (r !== 2) begin errors++; $display("FAIL wr_rvalid_latency: got %0d, required 2", r); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h, required 0", d); end
    checks++; if (occupancy_o !== 3'd1) begin errors++; $display("FAIL wr_occupancy: got %0d, required 1", occupancy_o); end
    repeat (3) @(negedge clk_i);
    checks++;
    if ({out_data_req_o, out_data_we_o, out_data_addr_o, out_data_be_o, out_data_wdata_o} !== {1'b1, 1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_out_hold: got req=%b we=%b a=%h be=%h wd=%h, required 1 1 0010 f deadbeef", out_data_req_o, out_data_we_o, out_data_addr_o, out_data_be_o, out_data_wdata_o);
    end
    checks++; if (drain_count !== 0) begin errors++; $display("FAIL wr_drain_early: got %0d, required 0", drain_count); end
    repeat (5) @(negedge clk_i);
    #2 wait_drain("single");
    checks++; if (drain_count !== 1) begin errors++; $display("FAIL wr_drain_count: got %0d, required 1", drain_count); end
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 16'h0010 || log_we[0] !== 1'b1 || log_wdata[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_mem_log: got %0d transactions, required one write of deadbeef to 0010", log_addr.size());
    end
    checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_mem_data: got %h, required deadbeef", mem[4]); end
  endtask

  task automatic test_full_stall();
    mem_stall = 1'b1;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    for (int i = 0; i < 4; i++) begin
      cache_req(16'(4*i), 1'b1, 4'hF, 32'hC0DE_0000 | i, g, r, d);
      checks++; if (g !== 1) begin errors++; $display("FAIL fill_gnt_%0d: got %0d, required 1", i, g); end
    end
    fork
      cache_req(16'h0010, 1'b1, 4'hF, 32'hC0DE_0004, g, r, d);
      begin
        repeat (7) @(negedge clk_i);
        checks++; if (full_stall_count !== 6) begin errors++; $display("FAIL stall_count_blocked: got %0d, required 6", full_stall_count); end
        checks++; if (occupancy_o !== 3'd4) begin errors++; $display("FAIL stall_occupancy: got %0d, required 4", occupancy_o); end
        checks++; if (in_data_gnt_o !== 1'b0) begin errors++; $display("FAIL stall_no_gnt: got %b, required 0", in_data_gnt_o); end
        #2 mem_stall = 1'b0;
      end
    join
    checks++; if (g !== 10) begin errors++; $display("FAIL stall_gnt_cycle: got %0d, required 10", g); end
    checks++; if (full_stall_count !== 9) begin errors++; $display("FAIL stall_count_final: got %0d, required 9", full_stall_count); end
    wait_drain("full");
    checks++; if (drain_count !== 6) begin errors++; $display("FAIL stall_drain_count: got %0d, required 6", drain_count); end
    checks++;
    if (log_addr.size() != 5) begin
      errors++; $display("FAIL stall_log_size: got %0d, required 5", log_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_addr[i] !== 16'(4*i) || log_we[i] !== 1'b1 || log_wdata[i] !== (32'hC0DE_0000 | i)) begin
          errors++; $display("FAIL stall_order_%0d: got a=%h wd=%h, required a=%h wd=%h", i, log_addr[i], log_wdata[i], 16'(4*i), 32'hC0DE_0000 | i);
        end
      end
    end
  endtask

  task automatic test_forward();
    mem_stall = 1'b1;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    cache_req(16'h0020, 1'b1, 4'hF, 32'h1234_5678, g, r, d);
    cache_req(16'h0020, 1'b0, 4'hF, 32'h0, g, r, d);
    checks++; if (g !== 1 || r !== 2) begin errors++; $display("FAIL fwd_latency: got gnt %0d rvalid %0d, required 1 2", g, r); end
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL fwd_rdata: got %h, required 12345678", d); end
    checks++; if (forward_count !== 1) begin errors++; $display("FAIL fwd_count: got %0d, required 1", forward_count); end
    cache_req(16'h0024, 1'b1, 4'hF, 32'h1111_1111, g, r, d);
    cache_req(16'h0024, 1'b1, 4'hF, 32'h2222_2222, g, r, d);
    cache_req(16'h0026, 1'b0, 4'hF, 32'h0, g, r, d);
    checks++; if (d !== 32'h2222_2222) begin errors++; $display("FAIL fwd_youngest: got %h, required 22222222", d); end
    checks++; if (forward_count !== 2) begin errors++; $display("FAIL fwd_count2: got %0d, required 2", forward_count); end
    wait_drain("fwd");
    checks++;
    if (log_addr.size() != 3 || log_we[0] !== 1'b1 || log_we[1] !== 1'b1 || log_we[2] !== 1'b1) begin
      errors++; $display("FAIL fwd_no_mem_read: got %0d transactions, required 3 writes only", log_addr.size());
    end
    checks++; if (drain_count !== 9) begin errors++; $display("FAIL fwd_drain_count: got %0d, required 9", drain_count); end
  endtask

  task automatic test_partial_conflict();
    mem_stall = 1'b1;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    cache_req(16'h0030, 1'b1, 4'h3, 32'h1111_BEEF, g, r, d);
    fork
      cache_req(16'h0030, 1'b0, 4'hF, 32'h0, g, r, d);
      begin
        repeat (7) @(negedge clk_i);
        checks++;
        if (out_data_req_o !== 1'b1 || out_data_we_o !== 1'b1 || in_data_gnt_o !== 1'b0) begin
          errors++; $display("FAIL part_wait: got req=%b we=%b ingnt=%b, required 1 1 0", out_data_req_o, out_data_we_o, in_data_gnt_o);
        end
        #2 mem_stall = 1'b0;
      end
    join
    checks++; if (d !== 32'hA500_BEEF) begin errors++; $display("FAIL part_rdata: got %h, required a500beef", d); end
    checks++; if (forward_count !== 2) begin errors++; $display("FAIL part_not_forwarded: got %0d, required 2", forward_count); end
    wait_drain("part");
    checks++;
    if (log_addr.size() != 2 || log_we[0] !== 1'b1 || log_we[1] !== 1'b0 || log_addr[1] !== 16'h0030) begin
      errors++; $display("FAIL part_order: got %0d transactions, required write then read of 0030", log_addr.size());
    end
  endtask

  task automatic test_read_priority();
    mem_stall = 1'b1;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    cache_req(16'h0050, 1'b1, 4'hF, 32'h5050_5050, g, r, d);
    cache_req(16'h0054, 1'b1, 4'hF, 32'h5454_5454, g, r, d);
    cache_req(16'h0058, 1'b1, 4'hF, 32'h5858_5858, g, r, d);
    fork
      cache_req(16'h0040, 1'b0, 4'hF, 32'h0, g, r, d);
      begin
        repeat (3) @(negedge clk_i);
        #2 mem_stall = 1'b0;
      end
    join
    checks++; if (d !== 32'hA500_0010) begin errors++; $display("FAIL prio_rdata: got %h, required a5000010", d); end
    wait_drain("prio");
    checks++;
    if (log_addr.size() != 4) begin
      errors++; $display("FAIL prio_log_size: got %0d, required 4", log_addr.size());
    end else begin
      checks++;
      if ({log_addr[0], log_addr[1], log_addr[2], log_addr[3]} !== {16'h0050, 16'h0040, 16'h0054, 16'h0058}) begin
        errors++; $display("FAIL prio_order: got %h %h %h %h, required 0050 0040 0054 0058", log_addr[0], log_addr[1], log_addr[2], log_addr[3]);
      end
      checks++;
      if ({log_we[0], log_we[1], log_we[2], log_we[3]} !== 4'b1011) begin
        errors++; $display("FAIL prio_we: got %b%b%b%b, required 1011", log_we[0], log_we[1], log_we[2], log_we[3]);
      end
    end
    checks++; if (drain_count !== 13) begin errors++; $display("FAIL prio_drain_count: got %0d, required 13", drain_count); end
  endtask

  task automatic test_reset_mid_drain();
    mem_stall = 1'b0;
    rv_delay = 5;
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    cache_req(16'h0060, 1'b1, 4'hF, 32'h6666_6666, g, r, d);
    repeat (2) @(negedge clk_i);
    checks++;
    if (out_data_req_o !== 1'b0 || occupancy_o !== 3'd1 || pend !== 1'b1) begin
      errors++; $display("FAIL rst_pre_state: got req=%b occ=%0d pend=%b, required 0 1 1", out_data_req_o, occupancy_o, pend);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({in_data_gnt_o, in_data_rvalid_o, out_data_req_o, occupancy_o} !== 6'd0 || in_data_rdata_o !== 32'd0) begin
      errors++; $display("FAIL rst_async_outputs: got gnt=%b rv=%b req=%b occ=%0d rd=%h, required all 0", in_data_gnt_o, in_data_rvalid_o, out_data_req_o, occupancy_o, in_data_rdata_o);
    end
    checks++;
    if (forward_count !== 0 || drain_count !== 0 || full_stall_count !== 0) begin
      errors++; $display("FAIL rst_async_counters: got fwd=%0d drn=%0d stall=%0d, required 0", forward_count, drain_count, full_stall_count);
    end
    @(negedge clk_i); #2 rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++;
    if (drain_count !== 0 || occupancy_o !== 3'd0 || out_data_req_o !== 1'b0 || pend !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid: got drn=%0d occ=%0d req=%b pend=%b, required 0 0 0 0", drain_count, occupancy_o, out_data_req_o, pend);
    end
    rv_delay = 0;
    cache_req(16'h0064, 1'b1, 4'hF, 32'h6464_6464, g, r, d);
    checks++; if (g !== 1 || r !== 2) begin errors++; $display("FAIL rst_next_write: got gnt %0d rvalid %0d, required 1 2", g, r); end
    wait_drain("rst");
    checks++; if (drain_count !== 1) begin errors++; $display("FAIL rst_drain_count: got %0d, required 1", drain_count); end
    checks++; if (mem[25] !== 32'h6464_6464) begin errors++; $display("FAIL rst_mem_data: got %h, required 64646464", mem[25]); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_stall();
    test_forward();
    test_partial_conflict();
    test_read_priority();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sayuru_write_buffer.md
Name: sayuru_write_buffer

Overview:
- Posted-write buffer between the direct-mapped data cache's memory-side port and data memory.
- Acknowledges cache write-backs and write misses immediately from a small FIFO, then drains them to memory in order.
- Forwards read data from buffered full-word writes. Other reads go to memory, bypassing non-conflicting writes.
- Both ports use the core memory protocol (req/gnt/rvalid); at most one transaction is outstanding per port.

Parameters:
- ADDR_WIDTH, 16, address width on both ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- DEPTH, 4, number of FIFO entries; must be a power of two and >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- in_data_req_i / in_data_addr_i / in_data_we_i / in_data_be_i / in_data_wdata_i  in  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  request from the cache.
- in_data_gnt_o / in_data_rvalid_o / in_data_rdata_o  out  1/1/DATA_WIDTH  response to the cache.
- out_data_req_o / out_data_addr_o / out_data_we_o / out_data_be_o / out_data_wdata_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  request to memory.
- out_data_gnt_i / out_data_rvalid_i / out_data_rdata_i  in  1/1/DATA_WIDTH  response from memory.
- occupancy_o  out  $clog2(DEPTH)+1  number of valid entries.
- forward_count, drain_count, full_stall_count  out  int  performance counters.

Behaviour:
- Reset: async clear of every output and counter to 0; FIFO pointers cleared and contents discarded; both FSMs return to idle. An in-flight memory transaction is abandoned and its late rvalid is ignored.
- Entry format: {addr, be, wdata}. Address match compares word addresses only (addr[ADDR_WIDTH-1:2]).
- FIFO pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full when pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - Push and pop in the same cycle leave occupancy unchanged.
- Upstream FSM states: U_IDLE, U_GNT, U_RESP, U_RD_WAIT, U_RD_MEM.
- U_IDLE, write (req&we):
  - If not full (registered full; no same-cycle bypass): push the entry, go to U_GNT.
  - If full: stay in U_IDLE and increment full_stall_count every such cycle.
- U_GNT: in_data_gnt_o=1 for exactly one cycle, then U_RESP.
- U_RESP: in_data_rvalid_o=1 for one cycle, then U_IDLE.
  - Writes return rdata=0; forwarded reads return the forwarded data.
- U_IDLE, read, youngest matching entry has be all-ones: latch that entry's data, increment forward_count, go to U_GNT. Total latency: gnt at +1 cycle, rvalid at +2 cycles.
- U_IDLE, read, any other case: go to U_RD_WAIT.
- U_RD_WAIT:
  - Wait until the downstream FSM is idle.
  - If any entry matches with partial be, also wait until the FIFO is empty.
  - Then hand the read to the downstream FSM and go to U_RD_MEM.
- Read priority: a pending read wins over starting the next drain. A drain already in progress always completes.
- U_RD_MEM:
  - Assert in_data_gnt_o for one cycle, in the cycle after out_data_gnt_i is sampled.
  - Assert in_data_rvalid_o, with out_data_rdata_i registered onto in_data_rdata_o, in the cycle after out_data_rvalid_i is sampled.
  - Then return to U_IDLE.
- Downstream FSM states: D_IDLE, D_REQ, D_WAIT_RVALID.
- D_IDLE:
  - Pending read: drive read fields with we=0, be from upstream; go to D_REQ.
  - Otherwise, if not empty: drive the head entry with we=1; go to D_REQ.
- D_REQ: hold req and all fields stable until out_data_gnt_i. On the gnt cycle, deassert req and clear the fields to 0; go to D_WAIT_RVALID.
- D_WAIT_RVALID: on out_data_rvalid_i, go to D_IDLE.
  - For a write: pop the head and increment drain_count.
  - The head stays visible to forwarding until the pop.
- Simultaneous events:
  - A write push in the same cycle as a drain pop is legal.
  - A forward-matched entry popped in the same cycle still returns the latched data.
- Ordering: writes drain in FIFO order. A read never overtakes a matching buffered write unless it is forwarded from the youngest full-word match.

Decomposition:
- Package sayuru_wb_pkg holds:
  - wb_entry_t struct {addr, be, data};
  - upstream and downstream state enums;
  - function word_match(a, b).
- Sub-module sayuru_wb_fifo holds entry storage and pointers, and exposes push/pop, full/empty, occupancy, plus a combinational lookup returning {hit, full_word, data} for the youngest match.

Test Plan:
- Write 0x0010 data 0xDEADBEEF be 0xF, memory gnt held low 10 cycles -> in gnt at +1, rvalid at +2, rdata 0; occupancy 1; drain issued when memory grants; drain_count 1.
- 5 writes to 0x0000,0x0004,...,0x0010, DEPTH 4, memory stalled -> 5th write sees no gnt; full_stall_count increments each blocked cycle; gnt issued the cycle after the first pop frees a slot; memory sees addresses in order.
- Write 0x0020=0x12345678 be 0xF, read 0x0020 while memory is stalled -> rdata 0x12345678 at +2 cycles; forward_count 1; no memory read issued.
- Write 0x0030 be 0x3, then read 0x0030 -> read waits until the FIFO is empty, then memory read issued; rdata equals memory data.
- Read 0x0040 (no match) with 2 writes buffered and one draining -> read issued right after the current drain's rvalid, before the remaining write.
- Assert rst_ni low mid-drain (D_WAIT_RVALID) -> all outputs 0 immediately; occupancy 0; post-reset memory rvalid ignored; next write accepted normally.
